// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), one bit per clock, LSB first, built on a mux-based full-subtractor cell.
// Latency: accept edge E0, WIDTH RUN edges, done pulses in the cycle after E_WIDTH; next accept no earlier than E_WIDTH+2.
// Backpressure: start is sampled only in IDLE and ignored while busy, so one operation is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin request, sampled only in IDLE
//   a, b       minuend / subtrahend, captured on the accepting edge
//   busy       high in RUN and DONE
//   done       one-cycle pulse when diff/borrow_out are updated
//   diff       a - b modulo 2^WIDTH, held until the next completion
//   borrow_out final borrow, 1 when a < b (unsigned)
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] r_sr_q;
    logic             borrow_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;

    logic             d_bit;
    logic             bo_bit;
    logic [WIDTH-1:0] r_sr_d;

    // Full-subtractor cell: both outputs are 4:1 muxes selected by
    // {a0,b0}, with the incoming borrow as the data input.
    always_comb begin
        d_bit  = borrow_q;
        bo_bit = borrow_q;
        unique case ({a_sr_q[0], b_sr_q[0]})
            2'b00: begin d_bit =  borrow_q; bo_bit = borrow_q; end
            2'b01: begin d_bit = ~borrow_q; bo_bit = 1'b1;     end
            2'b10: begin d_bit = ~borrow_q; bo_bit = 1'b0;     end
            2'b11: begin d_bit =  borrow_q; bo_bit = borrow_q; end
            default: begin d_bit = borrow_q; bo_bit = borrow_q; end
        endcase
    end

    // Result register fills from the MSB so that after WIDTH shifts the
    // first (LSB) difference bit has reached bit 0.
    always_comb begin
        r_sr_d            = r_sr_q >> 1;
        r_sr_d[WIDTH-1]   = d_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            r_sr_q       <= '0;
            borrow_q     <= 1'b0;
            count_q      <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    r_sr_q   <= r_sr_d;
                    borrow_q <= bo_bit;
                    count_q  <= count_q + CW'(1);
                    // Last bit: publish the result including this edge's bit.
                    if (count_q == LAST) begin
                        diff_q       <= r_sr_d;
                        borrow_out_q <= bo_bit;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Decoded from registered state only, so both are glitch-free.
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: doc/serial_full_subtractor.md
Name: serial_full_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, one bit per clock, LSB first.
- Built on a single full-subtractor cell whose difference and borrow are each produced by a 4x1 mux selected by {a_bit, b_bit}, with borrow-in as the data input. This is the subtraction counterpart of the mux-based full adder.
- Feeds a registered borrow flip-flop, operand shift registers and a result shift register.
- Sits beside the combinational adder/subtractor library as the area-minimal sequential arithmetic unit, with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (WIDTH >= 1)

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
busy  output  1  high in RUN and DONE
done  output  1  single-cycle pulse; results valid this cycle and held afterwards
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow_out  output  1  final borrow; 1 when a < b unsigned

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-RUN):
  - state = IDLE; busy = 0; done = 0; diff = 0; borrow_out = 0.
  - Internal shift registers, borrow flip-flop and bit counter cleared.
  - Release is synchronous to the next clk edge; the first start can be accepted on the first edge with rst_n high.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start = 1 at an edge: load a_sr <= a, b_sr <= b, borrow <= 0, count <= 0, go to RUN.
  - Otherwise stay in IDLE. diff and borrow_out hold their last values.
- RUN, one bit per edge:
  - The cell takes a_sr[0], b_sr[0] and borrow.
  - Difference: d = a0 ^ b0 ^ bin. As a mux with sel {a0,b0}: I0 = bin, I1 = ~bin, I2 = ~bin, I3 = bin.
  - Borrow: bo = (~a0 & b0) | (~(a0 ^ b0) & bin). As a mux with sel {a0,b0}: I0 = bin, I1 = 1, I2 = 0, I3 = bin.
  - Register updates: a_sr and b_sr shift right (MSB fill 0); r_sr shifts right with d inserted at the MSB; borrow <= bo; count <= count + 1.
  - On the edge where count == WIDTH-1:
    - diff <= final r_sr value (the bit computed on this edge included).
    - borrow_out <= bo.
    - Go to DONE.
- DONE:
  - done = 1 for exactly this one cycle; the next edge returns to IDLE.
  - start is ignored in DONE.
- busy = (state != IDLE). done = (state == DONE). Both are decoded from registered state, so they are glitch-free.
- Latency:
  - Accepting edge E0; RUN spans edges E1..E_WIDTH; done is high in the cycle after E_WIDTH.
  - The earliest next accept is edge E_WIDTH+2.
- Counter width is clog2(WIDTH) bits, minimum 1. For WIDTH = 1, RUN lasts exactly one edge.
- Boundary conditions:
  - start held high continuously: one operation per WIDTH+2 cycles, with no lost or duplicated done.
  - a and b changing during RUN or DONE: no effect; operands were captured at E0.
  - Equal operands give diff = 0, borrow_out = 0.
  - diff and borrow_out change only on the completion edge or on reset. They are stable through DONE and the following IDLE.

Test Plan:
- Reset, then a=100, b=37, start pulse -> busy high for 9 cycles; done high exactly 9 edges after acceptance; diff=63 (0x3F), borrow_out=0.
- a=5, b=9 -> diff=0xFC, borrow_out=1. Then a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
- a=b=0xFF, and separately a=0xA5, b=0x00 -> diff=0x00, borrow_out=0; diff=0xA5, borrow_out=0.
- start re-pulsed, and a/b changed to 0x00/0xFF, during RUN and in DONE of a 0x80-0x01 operation -> ignored; diff=0x7F, borrow_out=0; one done pulse only. start held high -> back-to-back results every 10 cycles.
- rst_n driven low asynchronously mid-RUN (between edges) -> busy, done, diff and borrow_out go to 0 immediately. After release, a new 0x10-0x20 operation gives diff=0xF0, borrow_out=1.
- WIDTH=1 instance, all four {a,b} combinations -> (diff,borrow_out) = 00, 11, 10, 00 for ab = 00, 01, 10, 11; done 2 edges after acceptance.
